ahb_default_slave: RTL and testbench
====================================

Name: ahb_default_slave

Overview:
- AHB responder that pairs with the address decoder.
- Selected by the decoder's default_slv_sel whenever a NONSEQ/SEQ transfer hits an unmapped region.
- Returns the protocol-mandated two-cycle ERROR response and logs the offending access (address, direction, count) for software and interrupt use.
- Sits in the interconnect slave-side mux as the "slave N+1" response source.

Parameters:
- AHB_ADDR_WIDTH, 32, width of haddr and the logged address
- AHB_DATA_WIDTH, 32, width of hrdata
- ERR_CNT_WIDTH, 8, width of the saturating error counter

Ports:
- hclk  in  1  bus clock, all logic on rising edge
- hreset  in  1  synchronous, active-high reset
- hsel  in  1  default-slave select (decoder default_slv_sel)
- haddr  in  AHB_ADDR_WIDTH  address-phase address
- htrans  in  htrans_type  transfer type (IDLE/BUSY/NONSEQ/SEQ)
- hwrite  in  1  address-phase direction, 1 = write
- hready  in  1  bus-level HREADY; address phase is valid only when high
- hreadyout  out  1  this slave's ready
- hresp  out  hresp_type  OKAY/ERROR
- hrdata  out  AHB_DATA_WIDTH  read data, tied to 0
- err_clr  in  1  clears err_valid and err_count
- err_valid  out  1  sticky: at least one error since last clear
- err_addr  out  AHB_ADDR_WIDTH  address of most recent erroneous transfer
- err_write  out  1  direction of most recent erroneous transfer
- err_count  out  ERR_CNT_WIDTH  number of errors, saturating
- err_irq  out  1  single-cycle pulse per accepted erroneous transfer

Behaviour:
- accept = hsel && hready && (htrans==NONSEQ || htrans==SEQ). IDLE and BUSY are never accepted.
- FSM states: ST_IDLE, ST_ERR1, ST_ERR2. Registered state; outputs decode from state only (Moore).
  - ST_IDLE: hreadyout=1, hresp=OKAY. accept -> ST_ERR1, else stay.
  - ST_ERR1: hreadyout=0, hresp=ERROR. Unconditional -> ST_ERR2. hready is low this cycle, so no accept is possible.
  - ST_ERR2: hreadyout=1, hresp=ERROR. accept -> ST_ERR1 (back-to-back error), else -> ST_IDLE. A master that cancels with IDLE returns the slave to ST_IDLE.
- Latency: ERROR is visible in the cycle after accept. The response spans exactly 2 cycles; the next accept can occur in the ERR2 cycle.
- hrdata is 0 at all times. Writes are discarded.
- Logging, on accept:
  - err_addr <= haddr, err_write <= hwrite, err_valid <= 1.
  - err_count <= err_count+1, saturating at all-ones (no wrap).
  - err_irq = 1 for exactly the cycle following accept, i.e. the first ST_ERR1 cycle.
- err_clr without accept: err_valid <= 0, err_count <= 0. err_addr and err_write hold.
- err_clr with accept in the same cycle: the capture wins. err_valid=1, err_count=1, err_addr/err_write take the new values.
- Reset (any state, including mid-response): next edge gives state=ST_IDLE, hreadyout=1, hresp=OKAY, err_valid=0, err_addr=0, err_write=0, err_count=0, err_irq=0. An in-flight ERROR is abandoned.
- hsel with hready low is ignored (wait state of another slave's data phase).

Decomposition:
- AHB_package gains:
  - hresp_type enum (OKAY, ERROR, RETRY, SPLIT), if not already present.
  - dslv_state_type enum {ST_IDLE, ST_ERR1, ST_ERR2}.
- Reuse the existing htrans_type.
- One sub-module: ahb_err_log, holding the capture registers, saturating counter, err_clr priority and err_irq pulse, driven by accept.
- The FSM stays in ahb_default_slave.

Test Plan:
- Reset, then idle bus (hsel=0, htrans=IDLE, hready=1) -> hreadyout=1, hresp=OKAY, err_valid=0, err_count=0.
- hsel=1, NONSEQ, haddr=0xDEAD_0000, hwrite=1, hready=1 for one cycle, then IDLE -> cycle+1: hreadyout=0/ERROR, err_irq=1; cycle+2: hreadyout=1/ERROR; cycle+3: OKAY. err_addr=0xDEAD_0000, err_write=1, err_count=1.
- Back-to-back NONSEQ 0x1000 then a second NONSEQ 0x2000 presented in the ERR2 cycle -> sequence ERR1, ERR2, ERR1, ERR2, IDLE. err_count=2, err_addr=0x2000.
- hsel=1 with htrans=BUSY, and separately NONSEQ with hready=0 -> no state change, OKAY, err_count unchanged.
- ERR_CNT_WIDTH=2: 5 accepted errors -> err_count saturates at 3. Then err_clr plus a simultaneous accept -> err_count=1, err_valid=1.
- hreset asserted during ST_ERR1 -> next cycle hreadyout=1, hresp=OKAY, all log outputs 0.

Source files
------------

// File: rtl/ahb_default_slave_pkg.sv
// Shared AHB types for the default (unmapped-region) responder.
package ahb_default_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_type;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERR1,
    ST_ERR2
  } dslv_state_type;

  function automatic logic is_active(input htrans_type t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave_err.sv
// Error log: captures the offending access, counts errors and pulses an interrupt.
module ahb_err_log #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write,
  input  logic                  clr,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_write,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_irq
);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_write <= 1'b0;
      err_count <= '0;
      err_irq   <= 1'b0;
    end else begin
      err_irq <= accept;
      // A capture in the same cycle as a clear wins and restarts the count at one.
      if (accept) begin
        err_valid <= 1'b1;
        err_addr  <= addr;
        err_write <= write;
        if (clr)
          err_count <= CNT_WIDTH'(1);
        else if (err_count != '1)
          err_count <= err_count + CNT_WIDTH'(1);
      end else if (clr) begin
        err_valid <= 1'b0;
        err_count <= '0;
      end
    end
  end

endmodule

// File: rtl/ahb_default_slave.sv
// AHB default slave: two-cycle ERROR response for unmapped transfers plus error logging.
module ahb_default_slave
  import ahb_default_slave_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned ERR_CNT_WIDTH  = 8
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  htrans_type                htrans,
  input  logic                      hwrite,
  input  logic                      hready,
  output logic                      hreadyout,
  output hresp_type                 hresp,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  input  logic                      err_clr,
  output logic                      err_valid,
  output logic [AHB_ADDR_WIDTH-1:0] err_addr,
  output logic                      err_write,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  output logic                      err_irq
);

  dslv_state_type state, next_state;
  logic           accept;

  assign accept = hsel && hready && is_active(htrans);
  assign hrdata = '0;

  always_ff @(posedge hclk) begin
    if (hreset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    hreadyout  = 1'b1;
    hresp      = OKAY;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_ERR1;
      end
      ST_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = ERROR;
        next_state = ST_ERR2;
      end
      ST_ERR2: begin
        hresp      = ERROR;
        next_state = accept ? ST_ERR1 : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  ahb_err_log #(
    .ADDR_WIDTH (AHB_ADDR_WIDTH),
    .CNT_WIDTH  (ERR_CNT_WIDTH)
  ) u_err_log (
    .clk       (hclk),
    .reset     (hreset),
    .accept    (accept),
    .addr      (haddr),
    .write     (hwrite),
    .clr       (err_clr),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_write (err_write),
    .err_count (err_count),
    .err_irq   (err_irq)
  );

endmodule

// File: tb/tb_ahb_default_slave.sv
// Bench for ahb_default_slave: directed scenarios plus randomized traffic against a behavioural model.
module tb_ahb_default_slave;
  import ahb_default_slave_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  htrans_type  htrans = IDLE;
  logic        hwrite = 1'b0;
  logic        hready = 1'b1;
  logic        err_clr = 1'b0;

  logic        hreadyout, err_valid, err_write, err_irq;
  hresp_type   hresp;
  logic [31:0] hrdata, err_addr;
  logic [7:0]  err_count;

  logic        hreadyout2, err_valid2, err_write2, err_irq2;
  hresp_type   hresp2;
  logic [31:0] hrdata2, err_addr2;
  logic [1:0]  err_count2;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Model: cycles of ERROR response still to show, plus the log contents.
  int          m_left = 0;
  logic        m_valid = 1'b0, m_write = 1'b0, m_irq = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_cnt8 = 0, m_cnt2 = 0;

  always #5 hclk = ~hclk;

  ahb_default_slave dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
    .hrdata(hrdata), .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr),
    .err_write(err_write), .err_count(err_count), .err_irq(err_irq)
  );

  ahb_default_slave #(.ERR_CNT_WIDTH(2)) dut2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hready(hready), .hreadyout(hreadyout2), .hresp(hresp2),
    .hrdata(hrdata2), .err_clr(err_clr), .err_valid(err_valid2), .err_addr(err_addr2),
    .err_write(err_write2), .err_count(err_count2), .err_irq(err_irq2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge hclk) begin
    bit acc;
    if (hreset) begin
      m_left = 0; m_valid = 1'b0; m_addr = '0; m_write = 1'b0;
      m_cnt8 = 0; m_cnt2 = 0; m_irq = 1'b0;
    end else begin
      acc = hsel && hready && (htrans == NONSEQ || htrans == SEQ);
      m_irq = acc;
      if (acc) begin
        m_valid = 1'b1; m_addr = haddr; m_write = hwrite;
        m_cnt8 = err_clr ? 1 : (m_cnt8 < 255 ? m_cnt8 + 1 : 255);
        m_cnt2 = err_clr ? 1 : (m_cnt2 < 3 ? m_cnt2 + 1 : 3);
      end else if (err_clr) begin
        m_valid = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
      end
      m_left = acc ? 2 : (m_left > 0 ? m_left - 1 : 0);
    end
  end

  always @(negedge hclk) begin
    if (check_en) begin
      chk("hreadyout", 64'(hreadyout), 64'(m_left != 2));
      chk("hresp", 64'(hresp), 64'(m_left > 0 ? ERROR : OKAY));
      chk("hrdata", 64'(hrdata), 64'd0);
      chk("err_valid", 64'(err_valid), 64'(m_valid));
      chk("err_addr", 64'(err_addr), 64'(m_addr));
      chk("err_write", 64'(err_write), 64'(m_write));
      chk("err_count", 64'(err_count), 64'(m_cnt8));
      chk("err_irq", 64'(err_irq), 64'(m_irq));
      chk("hresp_w2", 64'(hresp2), 64'(m_left > 0 ? ERROR : OKAY));
      chk("err_count_w2", 64'(err_count2), 64'(m_cnt2));
      chk("err_valid_w2", 64'(err_valid2), 64'(m_valid));
    end
  end

  // The bus drops hready while this slave holds the first ERROR cycle.
  task automatic cyc(input logic sel, input logic [31:0] addr, input htrans_type tr,
                     input logic wr, input logic rdy, input logic clr, input logic rst);
    hsel = sel; haddr = addr; htrans = tr; hwrite = wr;
    hready = (m_left == 2) ? 1'b0 : rdy;
    err_clr = clr; hreset = rst;
    @(posedge hclk);
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic hit(input logic [31:0] addr, input logic wr, input logic clr);
    cyc(1'b1, addr, NONSEQ, wr, 1'b1, clr, 1'b0);
  endtask

  initial begin
    cyc(1'b0, 32'h0, IDLE, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, IDLE, 1'b0, 1'b1, 1'b0, 1'b1);
    check_en = 1'b1;

    idle();
    chk("rst_ready", 64'(hreadyout), 64'd1);
    chk("rst_resp", 64'(hresp), 64'(OKAY));
    chk("rst_valid", 64'(err_valid), 64'd0);
    chk("rst_count", 64'(err_count), 64'd0);

    hit(32'hDEAD_0000, 1'b1, 1'b0);
    chk("e1_ready", 64'(hreadyout), 64'd0);
    chk("e1_resp", 64'(hresp), 64'(ERROR));
    chk("e1_irq", 64'(err_irq), 64'd1);
    chk("e1_addr", 64'(err_addr), 64'hDEAD_0000);
    chk("e1_write", 64'(err_write), 64'd1);
    chk("e1_count", 64'(err_count), 64'd1);
    idle();
    chk("e2_ready", 64'(hreadyout), 64'd1);
    chk("e2_resp", 64'(hresp), 64'(ERROR));
    chk("e2_irq", 64'(err_irq), 64'd0);
    idle();
    chk("e3_resp", 64'(hresp), 64'(OKAY));

    cyc(1'b0, 32'h0, IDLE, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_count", 64'(err_count), 64'd0);
    chk("clr_addr_hold", 64'(err_addr), 64'hDEAD_0000);
    hit(32'h1000, 1'b0, 1'b0);
    chk("b2b_err1a", 64'(hreadyout), 64'd0);
    idle();
    chk("b2b_err2a", 64'({hreadyout, hresp}), 64'({1'b1, ERROR}));
    hit(32'h2000, 1'b0, 1'b0);
    chk("b2b_err1b", 64'({hreadyout, hresp}), 64'({1'b0, ERROR}));
    idle();
    chk("b2b_err2b", 64'({hreadyout, hresp}), 64'({1'b1, ERROR}));
    idle();
    chk("b2b_idle", 64'({hreadyout, hresp}), 64'({1'b1, OKAY}));
    chk("b2b_count", 64'(err_count), 64'd2);
    chk("b2b_addr", 64'(err_addr), 64'h2000);

    cyc(1'b1, 32'h3000, BUSY, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("busy_resp", 64'({hreadyout, hresp}), 64'({1'b1, OKAY}));
    cyc(1'b1, 32'h3000, NONSEQ, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("nordy_resp", 64'({hreadyout, hresp}), 64'({1'b1, OKAY}));
    chk("nordy_count", 64'(err_count), 64'd2);

    cyc(1'b0, 32'h0, IDLE, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      hit(32'h4000 + i, 1'b1, 1'b0);
      idle();
    end
    chk("sat_w2", 64'(err_count2), 64'd3);
    chk("sat_w8", 64'(err_count), 64'd5);
    hit(32'h5000, 1'b0, 1'b1);
    chk("clracc_w2", 64'(err_count2), 64'd1);
    chk("clracc_valid", 64'(err_valid2), 64'd1);
    chk("clracc_addr", 64'(err_addr), 64'h5000);
    idle();
    idle();

    hit(32'h6000, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, IDLE, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rstmid_resp", 64'({hreadyout, hresp}), 64'({1'b1, OKAY}));
    chk("rstmid_log", 64'({err_valid, err_write, err_irq, err_addr, err_count}), 64'd0);
    idle();

    for (int unsigned i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, $urandom, htrans_type'($urandom_range(0, 3)),
          1'($urandom), ($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 97) == 0);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
